key_entry: RTL and testbench

KEY_ENTRY -- requirements
Module: key_entry

---
 rtl/key_entry_pkg.sv | 54 +++++
 rtl/key_entry_debounce.sv | 110 +++++++++++
 rtl/key_entry.sv | 131 +++++++++++++
 tb/tb_key_entry.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_entry_pkg.sv
// ---------------------------------------------------------------------------
// key_entry_pkg
// Shared definitions for the keypad entry block:
//   - debounce FSM state encoding
//   - special key codes ('*' and '#')
//   - entry limits (digit count and numeric ceiling)
//   - small helpers for digit classification and the x10 accumulate
// ---------------------------------------------------------------------------
package key_entry_pkg;

  // Debounce FSM states
  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_PRESS_WAIT   = 2'b01,
    ST_HELD         = 2'b10,
    ST_RELEASE_WAIT = 2'b11
  } deb_state_t;

  // Key code classes seen by the accumulator
  typedef enum logic [1:0] {
    KC_DIGIT = 2'b00,
    KC_STAR  = 2'b01,
    KC_HASH  = 2'b10,
    KC_NONE  = 2'b11
  } key_class_t;

  localparam logic [3:0]  KEY_STAR    = 4'b1010;
  localparam logic [3:0]  KEY_HASH    = 4'b1011;
  localparam logic [2:0]  MAX_DIGITS  = 3'd5;
  localparam logic [19:0] ENTRY_LIMIT = 20'd65535;

  // Classify a raw scanner code
  function automatic key_class_t classify_key(input logic [3:0] code);
    key_class_t kc;
    if (code <= 4'd9) begin
      kc = KC_DIGIT;
    end else if (code == KEY_STAR) begin
      kc = KC_STAR;
    end else if (code == KEY_HASH) begin
      kc = KC_HASH;
    end else begin
      kc = KC_NONE;
    end
    return kc;
  endfunction

  // entry*10 + digit carried at 20 bits so the range compare sees the
  // untruncated result (worst case 65535*10+9 fits in 20 bits)
  function automatic logic [19:0] mac10(input logic [15:0] acc,
                                        input logic [3:0]  digit);
    return ({4'b0000, acc} * 20'd10) + {16'h0000, digit};
  endfunction

endpackage

// File: rtl/key_entry_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// Synchronizes the raw key-activity flag and debounces it with a
// four-state FSM. Emits a single-cycle 'press' pulse in the cycle in which
// the FSM leaves PRESS_WAIT for HELD; the pulse is decoded from registered
// state only, so it is glitch-free.
//
// Ports
//   clk           in   system clock
//   rst_n         in   synchronous active-low reset
//   key_pad_flag  in   raw, possibly bouncing key-held flag
//   press         out  one-cycle pulse per debounced press
// ---------------------------------------------------------------------------
module key_debounce
  import key_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_pad_flag,
  output logic press
);

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic       sync_meta;
  logic       sync_flag;
  deb_state_t state;
  deb_state_t state_next;
  logic [15:0] cnt;
  logic [15:0] cnt_next;

  // Two-flop synchronizer for the raw flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_flag <= 1'b0;
    end else begin
      sync_meta <= key_pad_flag;
      sync_flag <= sync_meta;
    end
  end

  // FSM state and debounce counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 16'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state, counter and press decode
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    press      = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_next = 16'd0;
        if (sync_flag) begin
          state_next = ST_PRESS_WAIT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_PRESS_WAIT: begin
        if (!sync_flag) begin
          state_next = ST_IDLE;
          cnt_next   = 16'd0;
        end else if (cnt == CNT_LAST) begin
          state_next = ST_HELD;
          cnt_next   = 16'd0;
          press      = 1'b1;
        end else begin
          cnt_next   = cnt + 16'd1;
        end
      end
      ST_HELD: begin
        // No auto-repeat: holding the key simply parks here.
        cnt_next = 16'd0;
        if (!sync_flag) begin
          state_next = ST_RELEASE_WAIT;
        end else begin
          state_next = ST_HELD;
        end
      end
      ST_RELEASE_WAIT: begin
        if (sync_flag) begin
          // Bounce during release: fall back to HELD, never a new press.
          state_next = ST_HELD;
          cnt_next   = 16'd0;
        end else if (cnt == CNT_LAST) begin
          state_next = ST_IDLE;
          cnt_next   = 16'd0;
        end else begin
          cnt_next   = cnt + 16'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 16'd0;
      end
    endcase
  end

endmodule

// File: rtl/key_entry.sv
// ---------------------------------------------------------------------------
// key_entry
// Keypad number entry. A debounced press captures the scanner code and, one
// cycle later, pulses key_strobe together with the effect of that key:
//   digit : append to the decimal entry if it stays <= 65535 and fewer than
//           five digits are present, otherwise pulse ovf_err
//   '*'   : clear the entry
//   '#'   : commit a non-empty entry to value (value_valid pulse), clear it
//   other : strobe only
//
// Ports
//   clk           in   system clock
//   rst_n         in   synchronous active-low reset
//   key_pad[3:0]  in   scanner key code
//   key_pad_flag  in   raw key-held flag
//   key_strobe    out  one-cycle pulse per accepted press
//   key_code[3:0] out  code captured at the last accepted press
//   entry[15:0]   out  binary value of the digits typed so far
//   digit_count   out  number of digits in entry (0..5)
//   value[15:0]   out  last committed number
//   value_valid   out  one-cycle pulse when value is updated
//   ovf_err       out  one-cycle pulse when a digit is rejected
// ---------------------------------------------------------------------------
module key_entry
  import key_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  key_pad,
  input  logic        key_pad_flag,
  output logic        key_strobe,
  output logic [3:0]  key_code,
  output logic [15:0] entry,
  output logic [2:0]  digit_count,
  output logic [15:0] value,
  output logic        value_valid,
  output logic        ovf_err
);

  logic        press;
  key_class_t  key_class;
  logic [19:0] mac;
  logic        digit_ok;

  logic [15:0] entry_next;
  logic [2:0]  count_next;
  logic [15:0] value_next;
  logic        vv_next;
  logic        ovf_next;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_pad_flag(key_pad_flag),
    .press       (press)
  );

  // Decode the effect of the code present at the press edge
  always_comb begin
    key_class  = classify_key(key_pad);
    mac        = mac10(entry, key_pad);
    digit_ok   = (digit_count < MAX_DIGITS) && (mac <= ENTRY_LIMIT);
    entry_next = entry;
    count_next = digit_count;
    value_next = value;
    vv_next    = 1'b0;
    ovf_next   = 1'b0;
    case (key_class)
      KC_DIGIT: begin
        if (digit_ok) begin
          entry_next = mac[15:0];
          count_next = digit_count + 3'd1;
        end else begin
          ovf_next   = 1'b1;
        end
      end
      KC_STAR: begin
        entry_next = 16'd0;
        count_next = 3'd0;
      end
      KC_HASH: begin
        // An empty entry is not committed.
        if (digit_count != 3'd0) begin
          value_next = entry;
          vv_next    = 1'b1;
          entry_next = 16'd0;
          count_next = 3'd0;
        end else begin
          vv_next    = 1'b0;
        end
      end
      KC_NONE: begin
        entry_next = entry;
      end
      default: begin
        entry_next = entry;
      end
    endcase
  end

  // Output registers; pulses default low every cycle so none can stretch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_strobe  <= 1'b0;
      key_code    <= 4'b0000;
      entry       <= 16'd0;
      digit_count <= 3'd0;
      value       <= 16'd0;
      value_valid <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      key_strobe  <= 1'b0;
      value_valid <= 1'b0;
      ovf_err     <= 1'b0;
      if (press) begin
        key_strobe  <= 1'b1;
        key_code    <= key_pad;
        entry       <= entry_next;
        digit_count <= count_next;
        value       <= value_next;
        value_valid <= vv_next;
        ovf_err     <= ovf_next;
      end
    end
  end

endmodule

// File: tb/tb_key_entry.sv
// ---------------------------------------------------------------------------
// tb_key_entry
// Directed, table-driven bench for key_entry with DEBOUNCE_CYCLES = 8.
// Each table row is one key press; the expected captured code, entry,
// digit count, committed value and pulse flags are hand-computed.
// Bounce rejection and reset-during-debounce are separate sequences.
// ---------------------------------------------------------------------------
module tb_key_entry;
  import key_entry_pkg::*;

  localparam int DEB = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  key_pad;
  logic        key_pad_flag;
  logic        key_strobe;
  logic [3:0]  key_code;
  logic [15:0] entry;
  logic [2:0]  digit_count;
  logic [15:0] value;
  logic        value_valid;
  logic        ovf_err;

  always #5 clk = ~clk;

  key_entry #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_pad     (key_pad),
    .key_pad_flag(key_pad_flag),
    .key_strobe  (key_strobe),
    .key_code    (key_code),
    .entry       (entry),
    .digit_count (digit_count),
    .value       (value),
    .value_valid (value_valid),
    .ovf_err     (ovf_err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Output monitor sampled on the falling edge
  int          strobe_cnt = 0;
  int          vv_cnt     = 0;
  int          ovf_cnt    = 0;
  int          width_viol = 0;
  logic        prev_s = 1'b0, prev_v = 1'b0, prev_o = 1'b0;
  logic [3:0]  cap_code;
  logic [15:0] cap_entry;
  logic [2:0]  cap_count;
  logic [15:0] cap_value;
  logic        cap_vv;
  logic        cap_ovf;

  always @(negedge clk) begin
    if (key_strobe) begin
      strobe_cnt <= strobe_cnt + 1;
      cap_code   <= key_code;
      cap_entry  <= entry;
      cap_count  <= digit_count;
      cap_value  <= value;
      cap_vv     <= value_valid;
      cap_ovf    <= ovf_err;
    end
    if (value_valid) vv_cnt  <= vv_cnt + 1;
    if (ovf_err)     ovf_cnt <= ovf_cnt + 1;
    if ((key_strobe && prev_s) || (value_valid && prev_v) || (ovf_err && prev_o))
      width_viol <= width_viol + 1;
    prev_s <= key_strobe;
    prev_v <= value_valid;
    prev_o <= ovf_err;
  end

  typedef struct {
    logic [3:0]  key;
    int          hold;
    logic [3:0]  e_code;
    logic [15:0] e_entry;
    logic [2:0]  e_count;
    logic [15:0] e_value;
    logic        e_vv;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic press_key(input logic [3:0] k, input int hold);
    @(negedge clk);
    key_pad      = k;
    key_pad_flag = 1'b1;
    repeat (hold) @(negedge clk);
    key_pad_flag = 1'b0;
    repeat (20) @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_strobe"}, 32'(key_strobe), 32'd0);
    check({tag, "_code"},   32'(key_code),   32'd0);
    check({tag, "_entry"},  32'(entry),      32'd0);
    check({tag, "_count"},  32'(digit_count), 32'd0);
    check({tag, "_value"},  32'(value),      32'd0);
    check({tag, "_vv"},     32'(value_valid), 32'd0);
    check({tag, "_ovf"},    32'(ovf_err),    32'd0);
    check({tag, "_state"},  32'(dut.u_debounce.state), 32'(ST_IDLE));
  endtask

  initial begin
    int s0, v0, o0;
    bit found;

    //              key    hold  code   entry      cnt   value      vv    ovf
    vecs.push_back('{4'd5,  16, 4'd5,  16'd5,     3'd1, 16'd0,     1'b0, 1'b0});
    vecs.push_back('{4'd10, 16, 4'd10, 16'd0,     3'd0, 16'd0,     1'b0, 1'b0});
    vecs.push_back('{4'd6,  16, 4'd6,  16'd6,     3'd1, 16'd0,     1'b0, 1'b0});
    vecs.push_back('{4'd5,  16, 4'd5,  16'd65,    3'd2, 16'd0,     1'b0, 1'b0});
    vecs.push_back('{4'd5,  16, 4'd5,  16'd655,   3'd3, 16'd0,     1'b0, 1'b0});
    vecs.push_back('{4'd3,  16, 4'd3,  16'd6553,  3'd4, 16'd0,     1'b0, 1'b0});
    vecs.push_back('{4'd5,  16, 4'd5,  16'd65535, 3'd5, 16'd0,     1'b0, 1'b0});
    vecs.push_back('{4'd11, 16, 4'd11, 16'd0,     3'd0, 16'd65535, 1'b1, 1'b0});
    vecs.push_back('{4'd6,  16, 4'd6,  16'd6,     3'd1, 16'd65535, 1'b0, 1'b0});
    vecs.push_back('{4'd5,  16, 4'd5,  16'd65,    3'd2, 16'd65535, 1'b0, 1'b0});
    vecs.push_back('{4'd5,  16, 4'd5,  16'd655,   3'd3, 16'd65535, 1'b0, 1'b0});
    vecs.push_back('{4'd3,  16, 4'd3,  16'd6553,  3'd4, 16'd65535, 1'b0, 1'b0});
    vecs.push_back('{4'd6,  16, 4'd6,  16'd6553,  3'd4, 16'd65535, 1'b0, 1'b1});
    vecs.push_back('{4'd1,  16, 4'd1,  16'd65531, 3'd5, 16'd65535, 1'b0, 1'b0});
    vecs.push_back('{4'd2,  16, 4'd2,  16'd65531, 3'd5, 16'd65535, 1'b0, 1'b1});
    vecs.push_back('{4'd10, 16, 4'd10, 16'd0,     3'd0, 16'd65535, 1'b0, 1'b0});
    vecs.push_back('{4'd11, 1000, 4'd11, 16'd0,   3'd0, 16'd65535, 1'b0, 1'b0});
    vecs.push_back('{4'd12, 16, 4'd12, 16'd0,     3'd0, 16'd65535, 1'b0, 1'b0});
    vecs.push_back('{4'd15, 16, 4'd15, 16'd0,     3'd0, 16'd65535, 1'b0, 1'b0});
    vecs.push_back('{4'd7, 1000, 4'd7, 16'd7,     3'd1, 16'd65535, 1'b0, 1'b0});
    vecs.push_back('{4'd11, 16, 4'd11, 16'd0,     3'd0, 16'd7,     1'b1, 1'b0});
    vecs.push_back('{4'd0,  16, 4'd0,  16'd0,     3'd1, 16'd7,     1'b0, 1'b0});
    vecs.push_back('{4'd0,  16, 4'd0,  16'd0,     3'd2, 16'd7,     1'b0, 1'b0});
    vecs.push_back('{4'd0,  16, 4'd0,  16'd0,     3'd3, 16'd7,     1'b0, 1'b0});
    vecs.push_back('{4'd0,  16, 4'd0,  16'd0,     3'd4, 16'd7,     1'b0, 1'b0});
    vecs.push_back('{4'd1,  16, 4'd1,  16'd1,     3'd5, 16'd7,     1'b0, 1'b0});
    vecs.push_back('{4'd1,  16, 4'd1,  16'd1,     3'd5, 16'd7,     1'b0, 1'b1});
    vecs.push_back('{4'd11, 16, 4'd11, 16'd0,     3'd0, 16'd1,     1'b1, 1'b0});

    // Reset state
    rst_n        = 1'b0;
    key_pad_flag = 1'b0;
    key_pad      = 4'b1111;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Table-driven key presses
    for (int i = 0; i < vecs.size(); i++) begin
      s0 = strobe_cnt;
      v0 = vv_cnt;
      o0 = ovf_cnt;
      press_key(vecs[i].key, vecs[i].hold);
      check($sformatf("v%0d_strobes", i), 32'(strobe_cnt - s0), 32'd1);
      check($sformatf("v%0d_code", i),    32'(cap_code),  32'(vecs[i].e_code));
      check($sformatf("v%0d_entry", i),   32'(cap_entry), 32'(vecs[i].e_entry));
      check($sformatf("v%0d_count", i),   32'(cap_count), 32'(vecs[i].e_count));
      check($sformatf("v%0d_value", i),   32'(cap_value), 32'(vecs[i].e_value));
      check($sformatf("v%0d_vv", i),      32'(cap_vv),    32'(vecs[i].e_vv));
      check($sformatf("v%0d_ovf", i),     32'(cap_ovf),   32'(vecs[i].e_ovf));
      check($sformatf("v%0d_vv_total", i),  32'(vv_cnt - v0),  32'(vecs[i].e_vv));
      check($sformatf("v%0d_ovf_total", i), 32'(ovf_cnt - o0), 32'(vecs[i].e_ovf));
      check($sformatf("v%0d_live_entry", i), 32'(entry), 32'(vecs[i].e_entry));
    end

    // Bouncing flag: 3 high / 3 low for 30 cycles, never accepted
    s0 = strobe_cnt;
    key_pad = 4'd4;
    for (int b = 0; b < 5; b++) begin
      key_pad_flag = 1'b1;
      repeat (3) @(negedge clk);
      key_pad_flag = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (20) @(negedge clk);
    #1;
    check("bounce_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    check("bounce_state_idle", 32'(dut.u_debounce.state), 32'(ST_IDLE));
    check("bounce_entry", 32'(entry), 32'd0);

    // Reset while PRESS_WAIT counter is at 5
    key_pad      = 4'd3;
    key_pad_flag = 1'b1;
    found        = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (dut.u_debounce.state == ST_PRESS_WAIT && dut.u_debounce.cnt == 16'd5)
        found = 1'b1;
    end
    check("rst_reach_count5", 32'(found), 32'd1);
    s0    = strobe_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs("midrst");
    check("midrst_cnt", 32'(dut.u_debounce.cnt), 32'd0);
    rst_n = 1'b1;
    repeat (9) @(negedge clk);
    #1;
    check("midrst_no_early_strobe", 32'(strobe_cnt - s0), 32'd0);
    for (int c = 0; c < 30 && strobe_cnt == s0; c++) @(negedge clk);
    #1;
    check("midrst_strobe", 32'(strobe_cnt - s0), 32'd1);
    check("midrst_code", 32'(cap_code), 32'd3);
    check("midrst_entry", 32'(entry), 32'd3);
    check("midrst_count", 32'(digit_count), 32'd1);
    key_pad_flag = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    check("midrst_single_strobe", 32'(strobe_cnt - s0), 32'd1);

    check("pulse_width", 32'(width_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
